// File: rtl/spi_sram_ctrl.sv
// SPI-style serial front end for a small on-chip SRAM.
// Takes a 2-bit command and an address serially, then moves single words or bursts.
//
// Ports:
//   clock    - single clock, rising edge
//   reset    - synchronous, active-high
//   start    - one-cycle request to begin a transaction (IDLE only)
//   sdoM     - serial data from master, MSB first
//   sdoS     - serial read data to master, MSB first (0 outside RDATA)
//   comload  - command bits expected on sdoM
//   addrload - address bits expected on sdoM
//   dataload - data bits moving on sdoM (write) or sdoS (read)
//   busy     - any state other than IDLE
//   done     - one-cycle pulse at end of transaction
module spi_sram_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic sdoM,
    output logic sdoS,
    output logic comload,
    output logic addrload,
    output logic dataload,
    output logic busy,
    output logic done
);
    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam int WRD_W = $clog2(BURST_LEN + 1);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        COMM,
        ADDR,
        WDATA,
        RDATA,
        DONE
    } state_t;

    state_t            state;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WRD_W-1:0]  word_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] addr_inc;
    logic [DATA_W-1:0] wr_word;
    logic              addr_last;
    logic              data_last;
    logic              word_last;

    // addr_next includes the bit on sdoM so the first read word is
    // fetched on the same edge the address completes.
    assign addr_next = {addr[ADDR_W-2:0], sdoM};
    assign addr_inc  = addr + ADDR_W'(1);
    assign wr_word   = {shift[DATA_W-2:0], sdoM};
    assign addr_last = (bit_cnt == CNT_W'(ADDR_W - 1));
    assign data_last = (bit_cnt == CNT_W'(DATA_W - 1));
    assign word_last = (word_cnt == '0);

    assign comload  = (state == COMM);
    assign addrload = (state == ADDR);
    assign dataload = (state == WDATA) || (state == RDATA);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign sdoS     = (state == RDATA) && shift[DATA_W-1];

    // Memory has no reset; a reset edge suppresses the pending write.
    always_ff @(posedge clock) begin
        if (!reset && state == WDATA && data_last) begin
            mem[addr] <= wr_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cmd      <= '0;
            addr     <= '0;
            shift    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= COMM;
                        bit_cnt <= '0;
                    end
                end
                COMM: begin
                    cmd <= {cmd[0], sdoM};
                    if (bit_cnt == CNT_W'(1)) begin
                        state   <= ADDR;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                ADDR: begin
                    addr <= addr_next;
                    if (addr_last) begin
                        bit_cnt  <= '0;
                        word_cnt <= cmd[0] ? WRD_W'(BURST_LEN - 1) : '0;
                        if (cmd[1]) begin
                            state <= RDATA;
                            shift <= mem[addr_next];
                        end else begin
                            state <= WDATA;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                WDATA: begin
                    shift <= wr_word;
                    if (data_last) begin
                        bit_cnt <= '0;
                        if (word_last) begin
                            state <= DONE;
                        end else begin
                            word_cnt <= word_cnt - WRD_W'(1);
                            addr     <= addr_inc;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                RDATA: begin
                    if (data_last) begin
                        bit_cnt <= '0;
                        if (word_last) begin
                            state <= DONE;
                            shift <= '0;
                        end else begin
                            // next word loaded on this edge: no gap cycle
                            word_cnt <= word_cnt - WRD_W'(1);
                            addr     <= addr_inc;
                            shift    <= mem[addr_inc];
                        end
                    end else begin
                        shift   <= {shift[DATA_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_ctrl.sv
// Bench for spi_sram_ctrl: transaction-level reference model
// with per-cycle output comparison and literal pins.
module tb_spi_sram_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic sdoM  = 1'b0;
    logic sdoS;
    logic comload;
    logic addrload;
    logic dataload;
    logic busy;
    logic done;

    spi_sram_ctrl #(
        .ADDR_W(8),
        .DATA_W(8),
        .BURST_LEN(4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .sdoM    (sdoM),
        .sdoS    (sdoS),
        .comload (comload),
        .addrload(addrload),
        .dataload(dataload),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    // {comload, addrload, dataload, busy, done, sdoS}
    localparam logic [5:0] E_IDLE = 6'b000000;
    localparam logic [5:0] E_COMM = 6'b100100;
    localparam logic [5:0] E_ADDR = 6'b010100;
    localparam logic [5:0] E_DATA = 6'b001100;
    localparam logic [5:0] E_DONE = 6'b000110;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [5:0] last_got;
    logic [7:0] model [256];

    // Drive inputs for this cycle, compare outputs, advance one clock.
    task automatic step(input logic s, input logic m, input logic r,
                        input logic [5:0] e, input string nm);
        start = s;
        sdoM  = m;
        reset = r;
        last_got = {comload, addrload, dataload, busy, done, sdoS};
        checks++;
        if (last_got !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, last_got, e);
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // One transaction. abort_at: data bit index (w*8+b) at whose edge
    // reset is asserted, -1 for none. start_at: step index at which a
    // stray start is driven, -1 for none.
    task automatic run_txn(input bit rd, input bit burst, input int a0,
                           input logic [31:0] wd, input int abort_at,
                           input int start_at,
                           output logic [31:0] rbits, output int dl_cnt,
                           output int done_step, output int n_done);
        int n;
        int i;
        int a;
        logic [1:0] cmd;
        logic [7:0] av;
        logic [7:0] w8;
        logic [5:0] e;
        logic m;
        n = burst ? 4 : 1;
        cmd = {rd, burst};
        av = a0[7:0];
        rbits = '0;
        dl_cnt = 0;
        done_step = -1;
        n_done = 0;
        i = 0;
        step(1'b1, 1'b0, 1'b0, E_IDLE, "start");
        i++;
        for (int b = 1; b >= 0; b--) begin
            step(i == start_at, cmd[b], 1'b0, E_COMM, "comm");
            i++;
        end
        for (int b = 7; b >= 0; b--) begin
            step(i == start_at, av[b], 1'b0, E_ADDR, "addr");
            i++;
        end
        for (int w = 0; w < n; w++) begin
            a = (a0 + w) % 256;
            w8 = wd[(3 - w) * 8 +: 8];
            for (int b = 7; b >= 0; b--) begin
                if (rd) begin
                    e = E_DATA | {5'b0, model[a][b]};
                    m = 1'($urandom);
                end else begin
                    e = E_DATA;
                    m = w8[b];
                end
                if (w * 8 + (7 - b) == abort_at) begin
                    step(i == start_at, m, 1'b1, e, "abort_edge");
                    step(1'b0, 1'b0, 1'b0, E_IDLE, "after_reset");
                    return;
                end
                step(i == start_at, m, 1'b0, e, rd ? "rdata" : "wdata");
                if (last_got[3]) dl_cnt++;
                if (rd) rbits = {rbits[30:0], last_got[0]};
                i++;
            end
            if (!rd) model[a] = w8;
        end
        step(1'b0, 1'b0, 1'b0, E_DONE, "done");
        if (last_got[1]) begin
            done_step = i;
            n_done++;
        end
        step(1'b0, 1'b0, 1'b0, E_IDLE, "post_idle");
        if (last_got[1]) n_done++;
    endtask

    logic [31:0] rb;
    logic [31:0] wd;
    int dl;
    int ds;
    int nd;

    initial begin
        @(posedge clock);
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b1, E_IDLE, "reset_state");
        end
        step(1'b0, 1'b0, 1'b0, E_IDLE, "idle");

        // fill all of memory so later reads have defined contents
        for (int k = 0; k < 64; k++) begin
            wd = $urandom;
            run_txn(1'b0, 1'b1, k * 4, wd, -1, -1, rb, dl, ds, nd);
        end

        // single write then read
        run_txn(1'b0, 1'b0, 63, 32'h23000000, -1, -1, rb, dl, ds, nd);
        chk("write_done_step", 32'(ds), 32'd19);
        chk("write_done_cnt", 32'(nd), 32'd1);
        run_txn(1'b1, 1'b0, 63, 32'h0, -1, -1, rb, dl, ds, nd);
        chk("read63_bits", rb, 32'h00000023);
        chk("read63_dl", 32'(dl), 32'd8);

        // burst write / read wrapping across the top of memory
        run_txn(1'b0, 1'b1, 254, {8'd10, 8'd20, 8'd30, 8'd40},
                -1, -1, rb, dl, ds, nd);
        chk("burst_wr_dl", 32'(dl), 32'd32);
        run_txn(1'b1, 1'b1, 254, 32'h0, -1, -1, rb, dl, ds, nd);
        chk("burst_rd_bits", rb, {8'd10, 8'd20, 8'd30, 8'd40});
        chk("burst_rd_dl", 32'(dl), 32'd32);
        chk("burst_rd_done_step", 32'(ds), 32'd43);

        // reset after 5 of 8 write bits leaves old contents
        run_txn(1'b0, 1'b0, 100, 32'h07000000, -1, -1, rb, dl, ds, nd);
        run_txn(1'b0, 1'b0, 100, 32'hA5000000, 5, -1, rb, dl, ds, nd);
        step(1'b0, 1'b0, 1'b0, E_IDLE, "idle_after_abort");
        run_txn(1'b1, 1'b0, 100, 32'h0, -1, -1, rb, dl, ds, nd);
        chk("abort_keeps_old", rb, 32'h00000007);

        // stray start during address phase
        run_txn(1'b0, 1'b0, 17, 32'h5A000000, -1, 6, rb, dl, ds, nd);
        chk("stray_start_done_cnt", 32'(nd), 32'd1);
        chk("stray_start_done_step", 32'(ds), 32'd19);

        // reset wins over start
        step(1'b1, 1'b0, 1'b1, E_IDLE, "reset_and_start");
        step(1'b0, 1'b0, 1'b0, E_IDLE, "no_comm_after");
        step(1'b0, 1'b0, 1'b0, E_IDLE, "still_idle");

        // randomized transactions against the model
        for (int k = 0; k < 40; k++) begin
            int gap;
            wd = $urandom;
            run_txn(1'($urandom), 1'($urandom), int'($urandom_range(0, 255)),
                    wd, -1, -1, rb, dl, ds, nd);
            chk("rand_done_cnt", 32'(nd), 32'd1);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'($urandom), 1'b0, E_IDLE, "rand_gap");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spi_sram_ctrl.md
SPI_SRAM_CTRL -- requirements
Module: spi_sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning address width in bits; memory depth is 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-003 SHALL have parameter BURST_LEN, default 4, meaning words per burst transaction (>=2).
REQ-004 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a transaction.
REQ-007 SHALL have port sdoM  input  1  serial data from master, MSB first.
REQ-008 SHALL have port sdoS  output  1  serial read data to master, MSB first.
REQ-009 SHALL have port comload  output  1  high while command bits are expected on sdoM.
REQ-010 SHALL have port addrload  output  1  high while address bits are expected on sdoM.
REQ-011 SHALL have port dataload  output  1  high while data bits are shifted on sdoM (write) or sdoS (read).
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of transaction.

Function
REQ-014 SHALL implement states IDLE, COMM, ADDR, WDATA, RDATA, DONE; all outputs registered or decoded from the state register only.
REQ-015 SHALL leave IDLE for COMM on the rising edge where start=1; start SHALL be ignored in all other states.
REQ-016 SHALL stay in COMM 2 cycles, comload=1, sampling cmd[1] then cmd[0] from sdoM on rising edges; cmd[1]=1 read, 0 write; cmd[0]=1 burst, 0 single.
REQ-017 SHALL stay in ADDR ADDR_W cycles, addrload=1, shifting sdoM MSB first into the address register.
REQ-018 SHALL go from ADDR to WDATA (write) or RDATA (read); word count = BURST_LEN if cmd[0]=1, else 1.
REQ-019 WDATA: dataload=1 for DATA_W cycles per word; on the last bit edge SHALL write {shift[DATA_W-2:0], sdoM} to mem[addr] in the same edge.
REQ-020 RDATA: on entry SHALL load the shift register from mem[addr] using the complete address including its last bit; sdoS = shift MSB, shifted each cycle, DATA_W cycles per word, dataload=1.
REQ-021 After each word in a burst, addr SHALL increment modulo 2**ADDR_W (2**ADDR_W-1 wraps to 0); next read word SHALL be loaded from the incremented address with no gap cycle.
REQ-022 After the final word SHALL enter DONE for exactly 1 cycle (done=1, busy=1), then IDLE.
REQ-023 Single-transaction latency: start edge to done = 2+ADDR_W+DATA_W cycles in COMM/ADDR/DATA, done in the next cycle (defaults: done high in cycle 19 after start).
REQ-024 sdoS SHALL be 0 outside RDATA; loads SHALL be mutually exclusive.
REQ-025 Read of an address written in the same burst's earlier word, or a previous transaction, SHALL return the written value.

Reset
REQ-026 On reset=1 at a rising edge: state=IDLE; comload, addrload, dataload, sdoS, busy, done=0; shift, address, bit and word counters=0.
REQ-027 Reset mid-transaction SHALL abort with no memory write unless the word's last bit edge already occurred before the reset edge.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset SHALL take priority over start in the same cycle.

Verification
REQ-030 Single write then read: cmd 00, addr 63, data 35 -> mem[63]=35, done in cycle 19; read cmd 10 addr 63 -> sdoS 0,0,1,0,0,0,1,1.
REQ-031 Burst write wrap: cmd 01, addr 254, data 10,20,30,40 -> mem[254]=10, mem[255]=20, mem[0]=30, mem[1]=40; burst read cmd 11 addr 254 returns same sequence, 32 contiguous dataload cycles.
REQ-032 Reset mid-WDATA after 5 of 8 bits to addr 100 (prior value 7) -> mem[100]=7, all outputs 0 next cycle, busy=0.
REQ-033 start pulsed during ADDR of a write -> ignored; exactly one done pulse; busy stays 1 until DONE exits.
REQ-034 reset and start both high in one cycle -> state IDLE, comload=0 next cycle.
